// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state enum and default width for the restoring divider
package div_pkg;

    localparam int DIV_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one combinational restoring-division step
module div_restore_step #(
    parameter int N = 4
) (
    input  logic [N-1:0] rem_i,
    input  logic         bit_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] rem_o,
    output logic         q_o
);

    logic [N:0]   shifted;
    logic [N-1:0] diff;

    // A kept difference is always below the divisor, so its low N bits are exact.
    assign shifted = {rem_i, bit_i};
    assign q_o     = (shifted >= {1'b0, divisor_i});
    assign diff    = shifted[N-1:0] - divisor_i;
    assign rem_o   = q_o ? diff : shifted[N-1:0];

endmodule

// File: rtl/div_restore_8by4.sv
// rtl/div_restore_8by4.sv - sequential 2N-by-N restoring divider with valid/ready handshakes
// Optional DIV_EARLY_OUT_EN: skip iteration for zero divisor or dividend below divisor.
module div_restore_8by4
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [2*N-1:0] dividend_i,
    input  logic [N-1:0]   divisor_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [2*N-1:0] quotient_o,
    output logic [N-1:0]   remainder_o,
    output logic           ovf_o,
    output logic           dbz_o
);

    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] LAST_STEP = CW'(2 * N - 1);

    div_state_e     state_q;
    logic [2*N-1:0] dq_q;
    logic [N-1:0]   dvs_q;
    logic [N-1:0]   prem_q;
    logic [CW-1:0]  step_q;
    logic [2*N-1:0] quotient_q;
    logic [N-1:0]   remainder_q;
    logic           ovf_q;
    logic           dbz_q;
    logic           out_valid_q;

    logic [N-1:0]   prem_d;
    logic           qbit;
    logic [2*N-1:0] dq_d;

    div_restore_step #(.N(N)) u_step (
        .rem_i     (prem_q),
        .bit_i     (dq_q[2*N-1]),
        .divisor_i (dvs_q),
        .rem_o     (prem_d),
        .q_o       (qbit)
    );

    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign dq_d = {dq_q[2*N-2:0], qbit};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            dq_q        <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            step_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        dq_q   <= dividend_i;
                        dvs_q  <= divisor_i;
                        prem_q <= '0;
                        step_q <= '0;
`ifdef DIV_EARLY_OUT_EN
                        if (divisor_i == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= dividend_i[N-1:0];
                            ovf_q       <= 1'b1;
                            dbz_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else if (dividend_i < {{N{1'b0}}, divisor_i}) begin
                            quotient_q  <= '0;
                            remainder_q <= dividend_i[N-1:0];
                            ovf_q       <= 1'b0;
                            dbz_q       <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= RUN;
                        end
`else
                        state_q <= RUN;
`endif
                    end
                end
                RUN: begin
                    dq_q   <= dq_d;
                    prem_q <= prem_d;
                    step_q <= step_q + 1'b1;
                    if (step_q == LAST_STEP) begin
                        quotient_q  <= dq_d;
                        remainder_q <= prem_d;
                        ovf_q       <= |dq_d[2*N-1:N];
                        dbz_q       <= (dvs_q == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = out_valid_q;
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;
    assign ovf_o       = ovf_q;
    assign dbz_o       = dbz_q;

endmodule

// File: tb/tb_div_restore_8by4.sv
// tb/tb_div_restore_8by4.sv - directed self-checking bench for div_restore_8by4
module tb_div_restore_8by4;

`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_SHORT = 1;
`else
    localparam int LAT_SHORT = 9;
`endif
    localparam int LAT_FULL = 9;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       ovf;
    logic       dbz;

    int n_checks = 0;
    int n_fail   = 0;

    div_restore_8by4 dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .ovf_o       (ovf),
        .dbz_o       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_op(input logic [7:0] a, input logic [3:0] b, output int lat,
                         output logic [7:0] q, output logic [3:0] r,
                         output logic ov, output logic dz);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        q  = quotient;
        r  = remainder;
        ov = ovf;
        dz = dbz;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if ({quotient, remainder, ovf, dbz} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got q=%0d r=%0d ovf=%b dbz=%b want all 0", quotient, remainder, ovf, dbz);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] va [3];
        logic [3:0] vb [3];
        logic [7:0] eq [3];
        logic [3:0] er [3];
        logic       eo [3];
        int lat;
        logic [7:0] q;
        logic [3:0] r;
        logic ov, dz;
        va = '{8'd143, 8'd255, 8'd200};
        vb = '{4'd11, 4'd1, 4'd13};
        eq = '{8'd13, 8'd255, 8'd15};
        er = '{4'd0, 4'd0, 4'd5};
        eo = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], lat, q, r, ov, dz);
            n_checks++;
            if (lat !== LAT_FULL) begin n_fail++; $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, LAT_FULL); end
            n_checks++;
            if ({q, r, ov, dz} !== {eq[i], er[i], eo[i], 1'b0}) begin
                n_fail++;
                $display("FAIL basic_result[%0d]: got q=%0d r=%0d ovf=%b dbz=%b want q=%0d r=%0d ovf=%b dbz=0",
                         i, q, r, ov, dz, eq[i], er[i], eo[i]);
            end
            take_result();
            n_checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL basic_release[%0d]: got in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int lat;
        logic [7:0] q;
        logic [3:0] r;
        logic ov, dz;
        do_op(8'd100, 4'd0, lat, q, r, ov, dz);
        n_checks++;
        if (lat !== LAT_SHORT) begin n_fail++; $display("FAIL dbz_latency: got %0d want %0d", lat, LAT_SHORT); end
        n_checks++;
        if ({q, r, ov, dz} !== {8'hFF, 4'd4, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL dbz_result: got q=%0h r=%0d ovf=%b dbz=%b want q=ff r=4 ovf=1 dbz=1", q, r, ov, dz);
        end
        take_result();
    endtask

    task automatic test_early_out();
        int lat;
        logic [7:0] q;
        logic [3:0] r;
        logic ov, dz;
        do_op(8'd7, 4'd9, lat, q, r, ov, dz);
        n_checks++;
        if (lat !== LAT_SHORT) begin n_fail++; $display("FAIL small_latency: got %0d want %0d", lat, LAT_SHORT); end
        n_checks++;
        if ({q, r, ov, dz} !== {8'd0, 4'd7, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL small_result: got q=%0d r=%0d ovf=%b dbz=%b want q=0 r=7 ovf=0 dbz=0", q, r, ov, dz);
        end
        take_result();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [7:0] q;
        logic [3:0] r;
        logic ov, dz;
        do_op(8'd200, 4'd13, lat, q, r, ov, dz);
        in_valid = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd3;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, in_ready, quotient, remainder, ovf, dbz} !== {1'b1, 1'b0, 8'd15, 4'd5, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL hold[%0d]: got v=%b rdy=%b q=%0d r=%0d ovf=%b dbz=%b want v=1 rdy=0 q=15 r=5 ovf=0 dbz=0",
                         c, out_valid, in_ready, quotient, remainder, ovf, dbz);
            end
        end
        in_valid = 1'b0;
        take_result();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        repeat (12) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_ignored_input: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [7:0] q;
        logic [3:0] r;
        logic ov, dz;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 8'd143;
        divisor  = 4'd11;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, quotient, remainder} !== {1'b0, 1'b1, 8'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL abort_reset: got v=%b rdy=%b q=%0d r=%0d want v=0 rdy=1 q=0 r=0",
                     out_valid, in_ready, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'd225, 4'd15, lat, q, r, ov, dz);
        n_checks++;
        if (lat !== LAT_FULL) begin n_fail++; $display("FAIL abort_next_latency: got %0d want %0d", lat, LAT_FULL); end
        n_checks++;
        if ({q, r, ov, dz} !== {8'd15, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_next_result: got q=%0d r=%0d ovf=%b dbz=%b want q=15 r=0 ovf=0 dbz=0", q, r, ov, dz);
        end
        take_result();
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        rst_n     = 1'b1;
        test_reset();
        test_basic();
        test_div_by_zero();
        test_early_out();
        test_backpressure();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
